lsu: RTL and testbench
======================

Name: lsu

Overview:
Load/store unit placed directly downstream of the ALU in the RV32I core. It takes the ALU result as the effective address and runs one load or store over a valid/ready data-memory port. For stores it aligns and byte-masks the write data. For loads it sign- or zero-extends the read data. While the access is in flight it stalls the core.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in BUS state waiting for mem_ready before aborting; 0 disables the timeout.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  memory instruction in execute; held by core until done
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
req_addr  in  32  effective address (ALU result)
req_wdata  in  32  store data (rs2)
stall  out  1  hold PC/writeback
done  out  1  one-cycle completion pulse
rdata  out  32  extended load result
err  out  1  asserted with done when the access faulted
err_code  out  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none
mem_valid  out  1  bus request
mem_we  out  1  bus write
mem_addr  out  32  word address {req_addr[31:2],2'b00}
mem_wstrb  out  4  byte enables (0000 on loads)
mem_wdata  out  32  lane-replicated store data
mem_ready  in  1  bus accept/response
mem_rdata  in  32  bus read word, valid when mem_ready=1 on a load

Behaviour:
- Reset (sync): state=IDLE, timer=0; every registered output = 0 (mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, rdata, done, err, err_code).
- stall = req_valid && state!=DONE (combinational).
- FSM states: IDLE, BUS, DONE.
- IDLE, req_valid=0: stay.
- IDLE, req_valid=1, illegal funct3 (load 011/110/111; store any ≥011): go DONE with err_code=10, no bus access.
- IDLE, req_valid=1, misaligned (half with addr[0]=1; word with addr[1:0]!=0): go DONE with err_code=01, no bus access.
- IDLE, req_valid=1, otherwise: register the bus fields, go BUS.
- Byte store strobe: 0001<<addr[1:0]. Half store: 0011<<(2*addr[1]). Word store: 1111.
- Store data replication: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- BUS: mem_valid=1. Address, we, wstrb and wdata stay stable until the handshake; the request is never withdrawn except by rst.
- Handshake = mem_valid && mem_ready in the same cycle. On handshake, go DONE.
- On a load handshake, rdata is registered from the lane selected by addr[1:0]. Bytes are sign-extended for LB and zero-extended for LBU. Halves (lane addr[1]) are sign-extended for LH and zero-extended for LHU. LW takes the full word.
- Timer counts BUS cycles, with the first BUS cycle counting as 1. If TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES without a handshake: drop mem_valid, go DONE with err_code=11, rdata=0. A handshake in that same cycle wins over the timeout.
- DONE: done=1, err=(err_code!=0), stall=0 for exactly one cycle, mem_valid=0. Next state is IDLE, unconditionally.
- req_valid in the cycle after DONE belongs to the next instruction, so back-to-back ops cost no extra gap beyond IDLE.
- Latency: an aligned access with zero wait states raises stall in cycles 0–1 and done in cycle 2. Each cycle of mem_ready delay adds one cycle.
- rdata holds its last value until the next load completes. Stores and faults leave rdata unchanged, except a timed-out load, which writes rdata=0.
- mem_rdata is ignored on stores. mem_ready is ignored outside BUS.
- rst mid-BUS: next edge forces IDLE and mem_valid=0, with no done pulse.
- Deasserting req_valid mid-BUS is a core protocol violation. The access still completes and done still pulses.

Test Plan:
- LW, addr=0x100, mem_rdata=0xDEADBEEF, ready on first BUS cycle -> mem_addr=0x100, wstrb=0000, done in cycle 2, rdata=0xDEADBEEF, err=0.
- LB and LBU at addr=0x103, mem_rdata=0x80AA55CC -> LB rdata=0xFFFFFF80; LBU rdata=0x00000080.
- SH at addr=0x202, wdata=0x1234ABCD, ready delayed 3 cycles -> mem_addr=0x200, wstrb=1100, mem_wdata=0xABCDABCD, held stable 4 BUS cycles, done in cycle 5.
- LW at addr=0x101 -> no mem_valid, done next cycle with err=1, err_code=01; then funct3=011 load -> err_code=10.
- TIMEOUT_CYCLES=4, mem_ready=0 -> mem_valid high 4 cycles, then done with err_code=11, rdata=0; repeat with ready on the 4th cycle -> normal completion, err=0.
- rst=1 during BUS of an SW -> next cycle mem_valid=0, state IDLE, no done; a following LW completes normally.

Source files
------------

// File: rtl/lsu.sv
// RV32I load/store unit: one aligned access per instruction over a valid/ready
// data-memory port, with store lane steering, load extension and fault reporting.
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  dbg_state
);

   // Bus handshake: a beat transfers when mem_valid && mem_ready in the same
   // cycle; once raised, mem_valid and all mem_* fields hold until that beat
   // (or timeout/rst), and mem_ready is only looked at while in BUS.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);

   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    op_funct3;
   logic [1:0]    op_off;

   logic          illegal;
   logic          misaligned;
   logic [3:0]    strb;
   logic [31:0]   wdata_rep;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [31:0]   load_val;

   assign stall     = req_valid && (state != DONE);
   assign dbg_state = state;

   always_comb begin
      illegal    = 1'b0;
      misaligned = 1'b0;
      strb       = 4'b0000;
      wdata_rep  = req_wdata;
      if (req_we)
         illegal = req_funct3[2] | (req_funct3[1] & req_funct3[0]);
      else
         illegal = (req_funct3[1:0] == 2'b11) | (req_funct3[2:1] == 2'b11);
      case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = (req_addr[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
      case (req_funct3[1:0])
         2'b00: begin
            strb      = 4'b0001 << req_addr[1:0];
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            strb      = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{req_wdata[15:0]}};
         end
         default: begin
            strb      = 4'b1111;
            wdata_rep = req_wdata;
         end
      endcase
   end

   // Load lane is chosen by the offset latched at issue, not the live request.
   always_comb begin
      lane_b   = mem_rdata[{op_off, 3'b000} +: 8];
      lane_h   = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_val = mem_rdata;
      case (op_funct3)
         3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
         3'b100:  load_val = {24'd0, lane_b};
         3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
         3'b101:  load_val = {16'd0, lane_h};
         default: load_val = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         op_funct3 <= 3'd0;
         op_off    <= 2'd0;
         mem_valid <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wstrb <= 4'd0;
         mem_wdata <= 32'd0;
         rdata     <= 32'd0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (illegal) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     err      <= 1'b1;
                     err_code <= 2'b10;
                  end else if (misaligned) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     err      <= 1'b1;
                     err_code <= 2'b01;
                  end else begin
                     state     <= BUS;
                     timer     <= TW'(1);
                     op_funct3 <= req_funct3;
                     op_off    <= req_addr[1:0];
                     mem_valid <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wstrb <= req_we ? strb : 4'b0000;
                     mem_wdata <= req_we ? wdata_rep : 32'd0;
                  end
               end
            end
            BUS: begin
               if (mem_ready) begin
                  state     <= DONE;
                  mem_valid <= 1'b0;
                  done      <= 1'b1;
                  if (!mem_we)
                     rdata <= load_val;
               end else if ((TIMEOUT_CYCLES != 0) && (timer == T_LIMIT)) begin
                  state     <= DONE;
                  mem_valid <= 1'b0;
                  done      <= 1'b1;
                  err       <= 1'b1;
                  err_code  <= 2'b11;
                  if (!mem_we)
                     rdata <= 32'd0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               done     <= 1'b0;
               err      <= 1'b0;
               err_code <= 2'b00;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a transaction-level model predicts bus fields, fault
// codes, latency and load results; a per-cycle compare process checks them.
module tb_lsu;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        stall, done, err;
   logic [31:0] rdata;
   logic [1:0]  err_code;
   logic        mem_valid, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic [1:0]  dbg_state;

   lsu #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .done(done), .rdata(rdata), .err(err), .err_code(err_code),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [33:0] exp_q[$];
   logic [31:0] model_rdata;
   logic [31:0] cur_addr, cur_wdata;
   logic [3:0]  cur_strb;
   logic        cur_we;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_strb;
   logic [1:0]  last_ec;
   logic        last_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- model ----------------
   function automatic logic [1:0] model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      int size;
      if (we && f3 >= 3) return 2'b10;
      if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) return 2'b10;
      size = f3 % 4;
      if ((addr % (1 << size)) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
      int size, nbytes;
      size   = f3 % 4;
      nbytes = 1 << size;
      return 4'(((1 << nbytes) - 1) << (addr % 4));
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
      case (f3 % 4)
         0:       return {24'd0, w[7:0]} * 32'h01010101;
         1:       return {16'd0, w[15:0]} * 32'h00010001;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
      logic [31:0] b, h;
      int off;
      off = addr % 4;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 128) ? b - 32'd256 : b;
         3'b100:  return b;
         3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [33:0] e;
      if (!rst) begin
         check("stall", stall, req_valid && !done);
         if (mem_valid) begin
            check("mem_addr", mem_addr, cur_addr);
            check("mem_we", mem_we, cur_we);
            check("mem_wstrb", mem_wstrb, cur_strb);
            if (cur_we) check("mem_wdata", mem_wdata, cur_wdata);
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
               e = exp_q.pop_front();
               check("err_code", err_code, e[33:32]);
               check("err", err, e[33:32] != 2'b00);
               check("rdata", rdata, e[31:0]);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // delay = BUS cycles without ready before the accepting one; -1 = never ready.
   task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rword, input int delay);
      logic [1:0] ec;
      int cyc, bus, exp_cyc, exp_bus;
      bit got, timed_out;
      ec        = model_err(we, f3, addr);
      timed_out = (ec == 2'b00) && (delay < 0 || delay >= TIMEOUT);
      cur_addr  = {addr[31:2], 2'b00};
      cur_we    = we;
      cur_strb  = we ? model_strb(f3, addr) : 4'b0000;
      cur_wdata = model_wdata(f3, wdata);
      if (ec != 2'b00) begin
         exp_cyc = 1; exp_bus = 0;
      end else if (timed_out) begin
         ec = 2'b11; exp_cyc = TIMEOUT + 1; exp_bus = TIMEOUT;
         if (!we) model_rdata = 32'd0;
      end else begin
         exp_cyc = 2 + delay; exp_bus = delay + 1;
         if (!we) model_rdata = model_load(f3, addr, rword);
      end
      exp_q.push_back({ec, model_rdata});

      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
      req_wdata = wdata; mem_rdata = rword; mem_ready = 1'b0;
      cyc = 0; bus = 0; got = 0;
      while (!got && cyc < 40) begin
         if (mem_valid) begin
            mem_ready  = (bus == delay);
            bus++;
            last_addr  = mem_addr;
            last_strb  = mem_wstrb;
            last_wdata = mem_wdata;
         end else begin
            mem_ready = 1'b0;
         end
         if (done) begin
            got      = 1;
            last_ec  = err_code;
            last_err = err;
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      mem_ready = 1'b0;
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_wait: got no done in 40 cycles expected done in cycle %0d", exp_cyc);
         exp_q.delete();
      end else begin
         check("done_cycle", cyc, exp_cyc);
         check("bus_cycles", bus, exp_bus);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic reset_mid_bus();
      cur_addr = 32'h400; cur_we = 1'b1; cur_strb = 4'b1111; cur_wdata = 32'hCAFEF00D;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h400; req_wdata = 32'hCAFEF00D; mem_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("rstbus_valid_before", mem_valid, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstbus_valid", mem_valid, 1'b0);
      check("rstbus_state", dbg_state, 2'd0);
      check("rstbus_done", done, 1'b0);
      check("rstbus_rdata", rdata, 32'd0);
      rst = 1'b0;
      req_valid = 1'b0;
      model_rdata = 32'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
      model_rdata = 32'd0;
      cur_addr = 0; cur_we = 0; cur_strb = 0; cur_wdata = 0;
      repeat (2) begin @(posedge clk); #1; end
      check("rst_mem_valid", mem_valid, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wstrb", mem_wstrb, 4'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_done", done, 1'b0);
      check("rst_err", {err, err_code}, 3'd0);
      check("rst_state", dbg_state, 2'd0);
      check("rst_stall", stall, 1'b0);
      rst = 1'b0;

      // loads
      do_op(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0);
      check("lw_rdata_lit", rdata, 32'hDEADBEEF);
      check("lw_addr_lit", last_addr, 32'h100);
      check("lw_strb_lit", last_strb, 4'b0000);
      do_op(1'b0, 3'b000, 32'h103, 32'd0, 32'h80AA55CC, 0);
      check("lb_lit", rdata, 32'hFFFFFF80);
      do_op(1'b0, 3'b100, 32'h103, 32'd0, 32'h80AA55CC, 1);
      check("lbu_lit", rdata, 32'h00000080);
      do_op(1'b0, 3'b001, 32'h102, 32'd0, 32'h80AA55CC, 0);
      check("lh_lit", rdata, 32'hFFFF80AA);
      do_op(1'b0, 3'b101, 32'h100, 32'd0, 32'h80AA55CC, 2);
      check("lhu_lit", rdata, 32'h000055CC);
      do_op(1'b0, 3'b000, 32'h101, 32'd0, 32'h80AA55CC, 0);

      // stores (rdata must hold)
      do_op(1'b1, 3'b000, 32'h201, 32'h00000077, 32'hFFFFFFFF, 1);
      check("sb_strb_lit", last_strb, 4'b0010);
      check("sb_wdata_lit", last_wdata, 32'h77777777);
      do_op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'd0, 3);
      check("sh_addr_lit", last_addr, 32'h200);
      check("sh_strb_lit", last_strb, 4'b1100);
      check("sh_wdata_lit", last_wdata, 32'hABCDABCD);
      do_op(1'b1, 3'b010, 32'h300, 32'h13579BDF, 32'd0, 0);

      // faults
      do_op(1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 0);
      check("mis_ec_lit", {last_err, last_ec}, 3'b101);
      do_op(1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 0);
      check("ill_ec_lit", {last_err, last_ec}, 3'b110);
      do_op(1'b0, 3'b111, 32'h101, 32'd0, 32'd0, 0);
      do_op(1'b0, 3'b110, 32'h100, 32'd0, 32'd0, 0);
      do_op(1'b1, 3'b100, 32'h100, 32'd0, 32'd0, 0);
      do_op(1'b1, 3'b011, 32'h100, 32'd0, 32'd0, 0);
      do_op(1'b1, 3'b001, 32'h201, 32'd0, 32'd0, 0);
      do_op(1'b0, 3'b101, 32'h103, 32'd0, 32'd0, 0);
      do_op(1'b1, 3'b010, 32'h302, 32'd0, 32'd0, 0);

      // timeout boundary
      do_op(1'b0, 3'b010, 32'h500, 32'd0, 32'h11112222, -1);
      check("to_ec_lit", last_ec, 2'b11);
      check("to_rdata_lit", rdata, 32'd0);
      do_op(1'b0, 3'b010, 32'h504, 32'd0, 32'h33334444, 3);
      check("ready4_lit", {last_err, rdata}, {1'b0, 32'h33334444});
      do_op(1'b1, 3'b010, 32'h508, 32'h55556666, 32'd0, -1);
      check("st_to_rdata_lit", rdata, 32'h33334444);

      // reset in the middle of a store, then a clean load
      reset_mid_bus();
      do_op(1'b0, 3'b010, 32'h600, 32'd0, 32'h0BADF00D, 0);
      check("post_rst_lw_lit", rdata, 32'h0BADF00D);

      repeat (2) @(posedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
